frame_buffer_writer: RTL and testbench

//  Loads one image colour plane (one byte per pixel) into a channel frame-buffer RAM.

---
 rtl/vga_img_pkg.sv | 20 ++
 rtl/frame_buffer_writer.sv | 153 +++++++++++++++
 tb/tb_frame_buffer_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_img_pkg.sv
// Shared image geometry and FSM state type for the VGA channel frame-buffer blocks.
package vga_img_pkg;

    localparam int unsigned IMG_W     = 400;
    localparam int unsigned IMG_H     = 400;
    localparam int unsigned IMG_DEPTH = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        DONE
    } fsm_state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_buffer_writer.sv
// Loads one colour plane from a valid/ready byte stream into a frame-buffer RAM,
// issuing linear write requests through a single-entry output register.
module frame_buffer_writer #(
    parameter int unsigned IMG_W  = vga_img_pkg::IMG_W,
    parameter int unsigned IMG_H  = vga_img_pkg::IMG_H,
    parameter int unsigned DEPTH  = IMG_W * IMG_H,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              mem_wr_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count
);
    import vga_img_pkg::*;

    localparam int unsigned PIX_W = clog2_min1(DEPTH);
    localparam int unsigned COL_W = clog2_min1(IMG_W);
    localparam int unsigned ROW_W = clog2_min1(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    fsm_state_t        state_q, state_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       fcnt_q, fcnt_d;

    logic accept;
    logic last_pix;

    // The output slot frees up in the same cycle it drains, giving 1 byte/clk.
    assign in_ready = (state_q == WRITE) && (!wr_en_q || mem_wr_ready);
    assign accept   = in_valid && in_ready && !abort;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fcnt_d    = fcnt_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = WRITE;
                    pix_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!wr_en_q || mem_wr_ready) begin
                    state_d = DONE;
                    fcnt_d  = fcnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (wr_en_q && mem_wr_ready) begin
            wr_en_d = 1'b0;
        end

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(pix_q);
            wr_data_d = in_data;
            pix_d     = pix_q + PIX_W'(1);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end

        // Abort drops any pending write regardless of the RAM handshake.
        if (abort && ((state_q == WRITE) || (state_q == DRAIN))) begin
            wr_en_d = 1'b0;
        end

        busy_d = (state_d == WRITE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pix_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer on a 4x2 image.
module tb_frame_buffer_writer;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        mem_wr_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    frame_buffer_writer #(
        .IMG_W (W),
        .IMG_H (H),
        .DEPTH (D),
        .ADDR_W(32),
        .DATA_W(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_wr_ready(mem_wr_ready),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0]  send_q[$];
    logic [39:0] exp_q[$];
    int mode = 0;
    int cyc = 0;
    int exp_pix = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int first_acc = -1;
    int first_wr = -1;
    int last_wr = -1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Drive this cycle's inputs, settle, score the handshakes the next edge will take.
    task automatic tick();
        logic [39:0] e;
        mem_wr_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'b0;
        in_valid     = (send_q.size() > 0);
        in_data      = in_valid ? send_q[0] : 8'h00;
        #1;
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("wr_unexpected", 32'(wr_en), 32'd0);
                end else begin
                    e = exp_q[0];
                    check_eq("wr_addr", wr_addr, e[39:8]);
                    check_eq("wr_data", 32'(wr_data), 32'(e[7:0]));
                    if (mem_wr_ready && !abort) begin
                        void'(exp_q.pop_front());
                        wr_cnt++;
                        if (first_wr < 0) first_wr = cyc;
                        last_wr = cyc;
                    end else if (!mem_wr_ready) begin
                        check_eq("in_ready_stall", 32'(in_ready), 32'd0);
                    end
                end
            end
            if (abort) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back({32'(exp_pix), in_data});
                void'(send_q.pop_front());
                if (first_acc < 0) first_acc = cyc;
                exp_pix++;
            end
            if (done) done_cnt++;
        end else begin
            exp_q.delete();
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        cyc++;
    endtask

    task automatic load_bytes(input int n, input logic [7:0] base);
        send_q.delete();
        for (int i = 0; i < n; i++) send_q.push_back(base + 8'(i));
        exp_pix   = 0;
        first_acc = -1;
        first_wr  = -1;
        last_wr   = -1;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [7:0] base,
                             input int md, input int start_busy_at);
        int d0;
        int w0;
        bit sb;
        load_bytes(n, base);
        mode = md;
        d0 = done_cnt;
        w0 = wr_cnt;
        sb = 1'b0;
        start = 1'b1;
        tick();
        for (int k = 0; k < 80 && done_cnt == d0; k++) begin
            if (exp_pix == start_busy_at && !sb) begin
                start = 1'b1;
                sb = 1'b1;
            end
            tick();
        end
        for (int k = 0; k < 3; k++) tick();
        check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check_eq({tag, "_writes"}, 32'(wr_cnt - w0), 32'(D));
        check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check_eq("rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream with the RAM always ready
        run_frame("t1", 8, 8'h10, 0, -1);
        check_eq("t1_latency", 32'(first_wr - first_acc), 32'd1);
        check_eq("t1_consecutive", 32'(last_wr - first_wr), 32'(D - 1));
        check_eq("t1_frame_count", 32'(frame_count), 32'd1);

        // RAM ready toggling every cycle
        run_frame("t2", 8, 8'h10, 1, -1);
        check_eq("t2_frame_count", 32'(frame_count), 32'd2);

        // One byte too many
        run_frame("t3", 9, 8'h80, 0, -1);
        check_eq("t3_extra_left", 32'(send_q.size()), 32'd1);
        check_eq("t3_frame_count", 32'(frame_count), 32'd3);
        send_q.delete();
        tick();

        // Abort with a write pending
        load_bytes(8, 8'h30);
        mode = 0;
        d0 = done_cnt;
        start = 1'b1;
        tick();
        for (int k = 0; k < 20 && exp_pix < 3; k++) tick();
        check_eq("t4_pending", 32'(wr_en), 32'd1);
        mode = 2;
        abort = 1'b1;
        tick();
        check_eq("t4_wr_en", 32'(wr_en), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd0);
        send_q.delete();
        mode = 0;
        for (int k = 0; k < 4; k++) tick();
        check_eq("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check_eq("t4_frame_count", 32'(frame_count), 32'd3);
        run_frame("t4b", 8, 8'h40, 0, -1);
        check_eq("t4b_frame_count", 32'(frame_count), 32'd4);

        // start+abort together in IDLE, then start while busy
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        check_eq("t5_idle_wr_en", 32'(wr_en), 32'd0);
        run_frame("t5", 8, 8'h50, 1, 2);
        check_eq("t5_frame_count", 32'(frame_count), 32'd5);

        // Reset mid-frame
        load_bytes(8, 8'h60);
        mode = 0;
        start = 1'b1;
        tick();
        for (int k = 0; k < 20 && exp_pix < 3; k++) tick();
        rst_n = 1'b0;
        tick();
        check_eq("t6_wr_en", 32'(wr_en), 32'd0);
        check_eq("t6_wr_addr", wr_addr, 32'd0);
        check_eq("t6_wr_data", 32'(wr_data), 32'd0);
        check_eq("t6_in_ready", 32'(in_ready), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_done", 32'(done), 32'd0);
        check_eq("t6_frame_count", 32'(frame_count), 32'd0);
        rst_n = 1'b1;
        send_q.delete();
        tick();
        run_frame("t6b", 8, 8'h70, 0, -1);
        check_eq("t6b_frame_count", 32'(frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
